// File: rtl/rv32i_defs.sv
// Shared RV32I decode definitions: opcodes, ALU/writeback codes, NOP encoding
// and the decoded-control bundle passed from id_decoder to id_stage.
package rv32i_defs;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  mem_funct3;
        logic        reg_write;
        wb_sel_e     wb_sel;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic [2:0]  br_funct3;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/id_decoder.sv
// Purely combinational RV32I decoder: instruction word in, control bundle and
// selected immediate out. Unknown encodings come out as an all-zero NOP with illegal set.
module id_decoder
    import rv32i_defs::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        ill;
    dec_t        d;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        d   = '0;
        ill = 1'b0;
        case (opc)
            OPC_LUI: begin
                d.rd = inst[11:7]; d.imm = imm_u; d.alu_op = ALU_PASSB;
                d.alu_src_imm = 1'b1; d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                d.rd = inst[11:7]; d.imm = imm_u; d.alu_src_imm = 1'b1;
                d.alu_src_pc = 1'b1; d.reg_write = 1'b1;
            end
            OPC_JAL: begin
                d.rd = inst[11:7]; d.imm = imm_j; d.reg_write = 1'b1;
                d.wb_sel = WB_PC4; d.is_jal = 1'b1;
            end
            OPC_JALR: begin
                if (f3 != 3'b000) ill = 1'b1;
                d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = imm_i;
                d.alu_src_imm = 1'b1; d.reg_write = 1'b1; d.wb_sel = WB_PC4; d.is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
                d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.imm = imm_b;
                d.alu_op = ALU_SUB; d.is_branch = 1'b1; d.br_funct3 = f3;
            end
            OPC_LOAD: begin
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
                d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = imm_i; d.alu_src_imm = 1'b1;
                d.mem_read = 1'b1; d.reg_write = 1'b1; d.wb_sel = WB_MEM; d.mem_funct3 = f3;
            end
            OPC_STORE: begin
                if (f3[2] || f3 == 3'b011) ill = 1'b1;
                d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.imm = imm_s;
                d.alu_src_imm = 1'b1; d.mem_write = 1'b1; d.mem_funct3 = f3;
            end
            OPC_OP_IMM: begin
                d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = imm_i;
                d.alu_src_imm = 1'b1; d.reg_write = 1'b1;
                case (f3)
                    3'b000: d.alu_op = ALU_ADD;
                    3'b001: begin
                        d.alu_op = ALU_SLL;
                        if (f7 != 7'b0000000) ill = 1'b1;
                    end
                    3'b010: d.alu_op = ALU_SLT;
                    3'b011: d.alu_op = ALU_SLTU;
                    3'b100: d.alu_op = ALU_XOR;
                    3'b101: begin
                        if (f7 == 7'b0000000)      d.alu_op = ALU_SRL;
                        else if (f7 == 7'b0100000) d.alu_op = ALU_SRA;
                        else                       ill = 1'b1;
                    end
                    3'b110: d.alu_op = ALU_OR;
                    default: d.alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.rd = inst[11:7]; d.reg_write = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: d.alu_op = ALU_ADD;
                        3'b001: d.alu_op = ALU_SLL;
                        3'b010: d.alu_op = ALU_SLT;
                        3'b011: d.alu_op = ALU_SLTU;
                        3'b100: d.alu_op = ALU_XOR;
                        3'b101: d.alu_op = ALU_SRL;
                        3'b110: d.alu_op = ALU_OR;
                        default: d.alu_op = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d.alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d.alu_op = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            // FENCE, ECALL and EBREAK have no effect in this pipeline
            OPC_MISC_MEM, OPC_SYSTEM: ;
            default: ill = 1'b1;
        endcase

        if (ill) begin
            d = '0;
            d.illegal = 1'b1;
        end
        if (d.rd == 5'd0) d.reg_write = 1'b0;
    end

    assign dec = d;

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, in-ID branch/jump resolution and ID/EX register.
// Define RV32I_ILLEGAL_INST_EN to turn illegal encodings into bubbles and set o_illegal_seen.
module id_stage
    import rv32i_defs::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_fetch_pc,
    input  logic [31:0] i_pc_plus_4,
    input  logic        i_stall_id,
    output logic        o_pc_redirect,
    output logic [31:0] o_pc_redirect_target,
    output logic [4:0]  o_rs1_raddr,
    output logic [4:0]  o_rs2_raddr,
    input  logic [31:0] i_rs1_rdata,
    input  logic [31:0] i_rs2_rdata,
    output logic        o_ex_valid,
    output logic [31:0] o_ex_pc,
    output logic [31:0] o_ex_pc_plus_4,
    output logic [31:0] o_ex_rs1_data,
    output logic [31:0] o_ex_rs2_data,
    output logic [31:0] o_ex_imm,
    output logic [4:0]  o_ex_rs1,
    output logic [4:0]  o_ex_rs2,
    output logic [4:0]  o_ex_rd,
    output logic [3:0]  o_ex_alu_op,
    output logic        o_ex_alu_src_imm,
    output logic        o_ex_alu_src_pc,
    output logic        o_ex_mem_read,
    output logic        o_ex_mem_write,
    output logic [2:0]  o_ex_mem_funct3,
    output logic        o_ex_reg_write,
    output logic [1:0]  o_ex_wb_sel,
    output logic        o_illegal_seen
);

`ifdef RV32I_ILLEGAL_INST_EN
    localparam bit ILLEGAL_EN = 1'b1;
`else
    localparam bit ILLEGAL_EN = 1'b0;
`endif

    logic        ifid_valid;
    logic [31:0] ifid_inst, ifid_pc, ifid_pc4;
    logic [31:0] dec_inst;
    dec_t        dec;
    logic        br_taken;
    logic        ex_kill;
    logic        illegal_seen_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ifid_valid <= 1'b0;
            ifid_inst  <= NOP_INST;
            ifid_pc    <= RESET_ADDR;
            ifid_pc4   <= RESET_ADDR + 32'd4;
        end else if (!i_stall_id) begin
            if (o_pc_redirect) begin
                ifid_valid <= 1'b0;
            end else begin
                ifid_valid <= 1'b1;
                ifid_inst  <= i_inst;
                ifid_pc    <= i_fetch_pc;
                ifid_pc4   <= i_pc_plus_4;
            end
        end
    end

    // An empty IF/ID slot decodes as NOP so it never redirects or names registers
    assign dec_inst = ifid_valid ? ifid_inst : NOP_INST;

    id_decoder u_dec (
        .inst (dec_inst),
        .dec  (dec)
    );

    assign o_rs1_raddr = dec.rs1;
    assign o_rs2_raddr = dec.rs2;

    always_comb begin
        br_taken = 1'b0;
        case (dec.br_funct3)
            3'b000:  br_taken = (i_rs1_rdata == i_rs2_rdata);
            3'b001:  br_taken = (i_rs1_rdata != i_rs2_rdata);
            3'b100:  br_taken = ($signed(i_rs1_rdata) <  $signed(i_rs2_rdata));
            3'b101:  br_taken = ($signed(i_rs1_rdata) >= $signed(i_rs2_rdata));
            3'b110:  br_taken = (i_rs1_rdata <  i_rs2_rdata);
            3'b111:  br_taken = (i_rs1_rdata >= i_rs2_rdata);
            default: br_taken = 1'b0;
        endcase
    end

    assign o_pc_redirect = ifid_valid & !i_stall_id &
                           ((dec.is_branch & br_taken) | dec.is_jal | dec.is_jalr);
    assign o_pc_redirect_target = dec.is_jalr ? ((i_rs1_rdata + dec.imm) & 32'hFFFF_FFFE)
                                              : (ifid_pc + dec.imm);

    assign ex_kill = ILLEGAL_EN & dec.illegal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ex_valid       <= 1'b0;
            o_ex_pc          <= RESET_ADDR;
            o_ex_pc_plus_4   <= RESET_ADDR + 32'd4;
            o_ex_rs1_data    <= '0;
            o_ex_rs2_data    <= '0;
            o_ex_imm         <= '0;
            o_ex_rs1         <= '0;
            o_ex_rs2         <= '0;
            o_ex_rd          <= '0;
            o_ex_alu_op      <= '0;
            o_ex_alu_src_imm <= 1'b0;
            o_ex_alu_src_pc  <= 1'b0;
            o_ex_mem_read    <= 1'b0;
            o_ex_mem_write   <= 1'b0;
            o_ex_mem_funct3  <= '0;
            o_ex_reg_write   <= 1'b0;
            o_ex_wb_sel      <= '0;
        end else if (i_stall_id) begin
            o_ex_valid     <= 1'b0;
            o_ex_reg_write <= 1'b0;
            o_ex_mem_read  <= 1'b0;
            o_ex_mem_write <= 1'b0;
        end else begin
            o_ex_valid       <= ifid_valid & !ex_kill;
            o_ex_pc          <= ifid_pc;
            o_ex_pc_plus_4   <= ifid_pc4;
            o_ex_rs1_data    <= i_rs1_rdata;
            o_ex_rs2_data    <= i_rs2_rdata;
            o_ex_imm         <= dec.imm;
            o_ex_rs1         <= dec.rs1;
            o_ex_rs2         <= dec.rs2;
            o_ex_rd          <= dec.rd;
            o_ex_alu_op      <= dec.alu_op;
            o_ex_alu_src_imm <= dec.alu_src_imm;
            o_ex_alu_src_pc  <= dec.alu_src_pc;
            o_ex_mem_read    <= dec.mem_read;
            o_ex_mem_write   <= dec.mem_write;
            o_ex_mem_funct3  <= dec.mem_funct3;
            o_ex_reg_write   <= dec.reg_write;
            o_ex_wb_sel      <= dec.wb_sel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            illegal_seen_q <= 1'b0;
        else if (ILLEGAL_EN && ifid_valid && dec.illegal && !i_stall_id)
            illegal_seen_q <= 1'b1;
    end

    assign o_illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus a randomized stream
// checked against an instruction-level reference model of the decode stage.
module tb_id_stage;

    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BEQ   = 32'h0020_8463;  // beq x1,x2,+8
    localparam logic [31:0] JALR  = 32'h0042_80E7;  // jalr x1,4(x5)
    // ALU code per funct3 for the shared OP/OP-IMM table: ADD SLL SLT SLTU XOR SRL OR AND
    localparam logic [31:0] AMAP  = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};
`ifdef RV32I_ILLEGAL_INST_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic [31:0] pc, pc4, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        si, sp, mr, mw;
        logic [2:0]  mf3;
        logic        rw;
        logic [1:0]  wb;
    } ex_t;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        si, sp, mr, mw;
        logic [2:0]  mf3;
        logic        rw;
        logic [1:0]  wb;
        logic        jmp, jr, br;
        logic [2:0]  bf3;
        logic        ill;
    } ref_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = NOP, fpc = '0, fpc4 = 32'd4, a = '0, b = '0;
    logic        stall = 1'b0;

    logic        o_pc_redirect, o_illegal_seen;
    logic [31:0] o_pc_redirect_target;
    logic [4:0]  o_rs1_raddr, o_rs2_raddr;
    logic        o_ex_valid, o_ex_alu_src_imm, o_ex_alu_src_pc, o_ex_mem_read, o_ex_mem_write, o_ex_reg_write;
    logic [31:0] o_ex_pc, o_ex_pc_plus_4, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm;
    logic [4:0]  o_ex_rs1, o_ex_rs2, o_ex_rd;
    logic [3:0]  o_ex_alu_op;
    logic [2:0]  o_ex_mem_funct3;
    logic [1:0]  o_ex_wb_sel;
    ex_t         dut_ex;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic        m_ifv;
    logic [31:0] m_ifi, m_ifp, m_if4;
    ex_t         m_ex;
    logic        m_ill;
    logic [31:0] m_fpc;

    id_stage #(.RESET_ADDR(RST_A)) dut (
        .i_clk(clk), .i_rst(rst), .i_inst(inst), .i_fetch_pc(fpc), .i_pc_plus_4(fpc4),
        .i_stall_id(stall), .o_pc_redirect(o_pc_redirect), .o_pc_redirect_target(o_pc_redirect_target),
        .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr), .i_rs1_rdata(a), .i_rs2_rdata(b),
        .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_pc_plus_4(o_ex_pc_plus_4),
        .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data), .o_ex_imm(o_ex_imm),
        .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd), .o_ex_alu_op(o_ex_alu_op),
        .o_ex_alu_src_imm(o_ex_alu_src_imm), .o_ex_alu_src_pc(o_ex_alu_src_pc),
        .o_ex_mem_read(o_ex_mem_read), .o_ex_mem_write(o_ex_mem_write), .o_ex_mem_funct3(o_ex_mem_funct3),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_wb_sel(o_ex_wb_sel), .o_illegal_seen(o_illegal_seen)
    );

    assign dut_ex = {o_ex_valid, o_ex_pc, o_ex_pc_plus_4, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
                     o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_alu_op, o_ex_alu_src_imm, o_ex_alu_src_pc,
                     o_ex_mem_read, o_ex_mem_write, o_ex_mem_funct3, o_ex_reg_write, o_ex_wb_sel};

    always #5 clk = ~clk;

    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] ii, is, ib, iu, ij;
        f3 = w[14:12];
        f7 = w[31:25];
        ii = 32'($signed(w[31:20]));
        is = 32'($signed({w[31:25], w[11:7]}));
        ib = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        iu = {w[31:12], 12'h000};
        ij = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        r = '0;
        case (w[6:0])
            7'h37: begin r.rd = w[11:7]; r.imm = iu; r.alu = 4'd10; r.si = 1; r.rw = 1; end
            7'h17: begin r.rd = w[11:7]; r.imm = iu; r.si = 1; r.sp = 1; r.rw = 1; end
            7'h6F: begin r.rd = w[11:7]; r.imm = ij; r.rw = 1; r.wb = 2; r.jmp = 1; end
            7'h67: begin
                r.rs1 = w[19:15]; r.rd = w[11:7]; r.imm = ii; r.si = 1; r.rw = 1; r.wb = 2; r.jr = 1;
                r.ill = (f3 != 0);
            end
            7'h63: begin
                r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.imm = ib; r.alu = 4'd1; r.br = 1; r.bf3 = f3;
                r.ill = (f3 == 2 || f3 == 3);
            end
            7'h03: begin
                r.rs1 = w[19:15]; r.rd = w[11:7]; r.imm = ii; r.si = 1; r.mr = 1; r.rw = 1; r.wb = 1; r.mf3 = f3;
                r.ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin
                r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.imm = is; r.si = 1; r.mw = 1; r.mf3 = f3;
                r.ill = (f3 > 2);
            end
            7'h13: begin
                r.rs1 = w[19:15]; r.rd = w[11:7]; r.imm = ii; r.si = 1; r.rw = 1;
                r.alu = AMAP[f3*4 +: 4];
                if (f3 == 1 && f7 != 0) r.ill = 1;
                if (f3 == 5 && f7 == 7'h20) r.alu = 4'd7;
                if (f3 == 5 && f7 != 0 && f7 != 7'h20) r.ill = 1;
            end
            7'h33: begin
                r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7]; r.rw = 1;
                if (f7 == 0) r.alu = AMAP[f3*4 +: 4];
                else if (f7 == 7'h20 && f3 == 0) r.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 5) r.alu = 4'd7;
                else r.ill = 1;
            end
            7'h0F, 7'h73: ;
            default: r.ill = 1;
        endcase
        if (r.ill) begin
            r = '0;
            r.ill = 1;
        end
        if (r.rd == 0) r.rw = 0;
        return r;
    endfunction

    function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd4: return $signed(x) < $signed(y);
            3'd5: return $signed(x) >= $signed(y);
            3'd6: return x < y;
            3'd7: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ref_t cur_dec();
        return ref_decode(m_ifv ? m_ifi : NOP);
    endfunction

    function automatic logic exp_red();
        ref_t d;
        d = cur_dec();
        return m_ifv && !stall && (d.jmp || d.jr || (d.br && ref_taken(d.bf3, a, b)));
    endfunction

    function automatic logic [31:0] exp_tgt();
        ref_t d;
        d = cur_dec();
        return d.jr ? ((a + d.imm) & 32'hFFFF_FFFE) : (m_ifp + d.imm);
    endfunction

    task automatic drive(input logic [31:0] w, input logic [31:0] pc, input logic st,
                         input logic [31:0] x, input logic [31:0] y);
        inst = w; fpc = pc; fpc4 = pc + 32'd4; stall = st; a = x; b = y;
        #1;
    endtask

    // one clock edge, with the reference model advanced from the pre-edge inputs
    task automatic tick();
        ref_t d;
        logic red;
        d   = cur_dec();
        red = exp_red();
        @(posedge clk);
        #1;
        if (rst) begin
            m_ifv = 0; m_ifi = NOP; m_ifp = RST_A; m_if4 = RST_A + 32'd4;
            m_ex = '0; m_ex.pc = RST_A; m_ex.pc4 = RST_A + 32'd4; m_ill = 0;
        end else if (stall) begin
            m_ex.v = 0; m_ex.rw = 0; m_ex.mr = 0; m_ex.mw = 0;
        end else begin
            m_ex = '{v: m_ifv && !(ILL_EN && d.ill), pc: m_ifp, pc4: m_if4, d1: a, d2: b, imm: d.imm,
                     rs1: d.rs1, rs2: d.rs2, rd: d.rd, alu: d.alu, si: d.si, sp: d.sp, mr: d.mr,
                     mw: d.mw, mf3: d.mf3, rw: d.rw, wb: d.wb};
            if (ILL_EN && m_ifv && d.ill) m_ill = 1;
            if (red) m_ifv = 0;
            else begin m_ifv = 1; m_ifi = inst; m_ifp = fpc; m_if4 = fpc4; end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        drive(NOP, 32'h0, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if (dut_ex !== m_ex) begin n_fail++; $display("FAIL reset_ex got %h want %h", dut_ex, m_ex); end
        n_checks++;
        if (o_ex_pc_plus_4 !== RST_A + 32'd4 || o_ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_pc4 got %h/%b want %h/0", o_ex_pc_plus_4, o_ex_valid, RST_A + 32'd4);
        end
        n_checks++;
        if (o_pc_redirect !== 1'b0 || o_illegal_seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got red=%b ill=%b want 0 0", o_pc_redirect, o_illegal_seen);
        end
        rst = 0;
    endtask

    task automatic test_addi();
        drive(32'h0050_0093, 32'h0, 0, 0, 0);
        tick();
        drive(NOP, 32'h4, 0, 0, 0);
        tick();
        n_checks++;
        if ({o_ex_valid, o_ex_rd, o_ex_imm, o_ex_alu_op, o_ex_reg_write} !== {1'b1, 5'd1, 32'd5, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL addi got v=%b rd=%0d imm=%h alu=%0d rw=%b want 1 1 5 0 1",
                     o_ex_valid, o_ex_rd, o_ex_imm, o_ex_alu_op, o_ex_reg_write);
        end
        n_checks++;
        if (dut_ex !== m_ex) begin n_fail++; $display("FAIL addi_ex got %h want %h", dut_ex, m_ex); end
    endtask

    task automatic test_branch_taken();
        drive(BEQ, 32'h10, 0, 32'd7, 32'd7);
        tick();
        drive(32'h0030_0193, 32'h14, 0, 32'd7, 32'd7);
        n_checks++;
        if (o_pc_redirect !== 1'b1 || o_pc_redirect_target !== 32'h18) begin
            n_fail++; $display("FAIL beq_taken got red=%b tgt=%h want 1 00000018", o_pc_redirect, o_pc_redirect_target);
        end
        n_checks++;
        if ({o_rs1_raddr, o_rs2_raddr} !== {5'd1, 5'd2}) begin
            n_fail++; $display("FAIL beq_raddr got %0d,%0d want 1,2", o_rs1_raddr, o_rs2_raddr);
        end
        tick();
        n_checks++;
        if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h10) begin
            n_fail++; $display("FAIL beq_in_ex got v=%b pc=%h want 1 00000010", o_ex_valid, o_ex_pc);
        end
        drive(NOP, 32'h18, 0, 0, 0);
        n_checks++;
        if (o_pc_redirect !== 1'b0) begin n_fail++; $display("FAIL squash_red got %b want 0", o_pc_redirect); end
        tick();
        n_checks++;
        if (o_ex_valid !== 1'b0) begin n_fail++; $display("FAIL squash_bubble got v=%b want 0", o_ex_valid); end
    endtask

    task automatic test_branch_not_taken();
        drive(BEQ, 32'h10, 0, 32'd7, 32'd8);
        tick();
        drive(32'h0030_0193, 32'h14, 0, 32'd7, 32'd8);
        n_checks++;
        if (o_pc_redirect !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken got red=%b want 0", o_pc_redirect); end
        tick();
        drive(NOP, 32'h18, 0, 0, 0);
        tick();
        n_checks++;
        if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h14) begin
            n_fail++; $display("FAIL no_bubble got v=%b pc=%h want 1 00000014", o_ex_valid, o_ex_pc);
        end
    endtask

    task automatic test_jalr_stall();
        drive(JALR, 32'h20, 0, 32'h101, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(NOP, 32'h24, 1, 32'h101, 0);
            n_checks++;
            if (o_pc_redirect !== 1'b0) begin n_fail++; $display("FAIL jalr_stall_red[%0d] got %b want 0", i, o_pc_redirect); end
            tick();
            n_checks++;
            if (o_ex_valid !== 1'b0 || o_ex_reg_write !== 1'b0) begin
                n_fail++; $display("FAIL jalr_stall_bubble[%0d] got v=%b rw=%b want 0 0", i, o_ex_valid, o_ex_reg_write);
            end
        end
        drive(NOP, 32'h24, 0, 32'h101, 0);
        n_checks++;
        if (o_pc_redirect !== 1'b1 || o_pc_redirect_target !== 32'h104) begin
            n_fail++; $display("FAIL jalr_target got red=%b tgt=%h want 1 00000104", o_pc_redirect, o_pc_redirect_target);
        end
        tick();
        n_checks++;
        if ({o_ex_valid, o_ex_wb_sel, o_ex_pc, o_ex_rd} !== {1'b1, 2'd2, 32'h20, 5'd1}) begin
            n_fail++; $display("FAIL jalr_ex got v=%b wb=%0d pc=%h rd=%0d want 1 2 00000020 1",
                               o_ex_valid, o_ex_wb_sel, o_ex_pc, o_ex_rd);
        end
    endtask

    task automatic test_x0_and_reset();
        drive(32'h0010_0013, 32'h40, 0, 0, 0);
        tick();
        drive(BEQ, 32'h44, 0, 32'd7, 32'd7);
        tick();
        n_checks++;
        if (o_ex_valid !== 1'b1 || o_ex_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL x0_write got v=%b rw=%b want 1 0", o_ex_valid, o_ex_reg_write);
        end
        drive(NOP, 32'h48, 0, 32'd7, 32'd7);
        rst = 1;
        tick();
        rst = 0;
        #1;
        n_checks++;
        if (o_ex_valid !== 1'b0 || o_pc_redirect !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got v=%b red=%b want 0 0", o_ex_valid, o_pc_redirect);
        end
    endtask

    task automatic test_illegal();
        drive(32'h0000_0080, 32'h50, 0, 0, 0);
        tick();
        drive(NOP, 32'h54, 0, 0, 0);
        tick();
        n_checks++;
        if (o_ex_valid !== !ILL_EN || o_illegal_seen !== ILL_EN || o_ex_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL illegal got v=%b seen=%b rw=%b want %b %b 0",
                               o_ex_valid, o_illegal_seen, o_ex_reg_write, !ILL_EN, ILL_EN);
        end
        tick();
        n_checks++;
        if (o_illegal_seen !== ILL_EN) begin n_fail++; $display("FAIL illegal_sticky got %b want %b", o_illegal_seen, ILL_EN); end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 14))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  begin w[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b000; end
            4, 5: w[6:0] = 7'h63;
            6:  w[6:0] = 7'h03;
            7:  w[6:0] = 7'h23;
            8:  w[6:0] = 7'h13;
            9:  begin w[6:0] = 7'h33; w[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20; end
            10: w[6:0] = 7'h33;
            11: w[6:0] = $urandom_range(0, 1) ? 7'h0F : 7'h73;
            12: w[6:0] = 7'h00;
            13: w = NOP;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_random();
        ref_t d;
        logic red;
        logic [31:0] tgt;
        m_fpc = 32'h100;
        for (int i = 0; i < 600; i++) begin
            drive(rand_inst(), m_fpc, ($urandom_range(0, 4) == 0), $urandom, 32'd0);
            if ($urandom_range(0, 1) != 0) b = a; else b = $urandom;
            #1;
            d   = cur_dec();
            red = exp_red();
            tgt = exp_tgt();
            n_checks++;
            if ({o_rs1_raddr, o_rs2_raddr} !== {d.rs1, d.rs2}) begin
                n_fail++; $display("FAIL rnd_raddr[%0d] got %0d,%0d want %0d,%0d", i, o_rs1_raddr, o_rs2_raddr, d.rs1, d.rs2);
            end
            n_checks++;
            if (o_pc_redirect !== red) begin
                n_fail++; $display("FAIL rnd_redirect[%0d] got %b want %b", i, o_pc_redirect, red);
            end
            if (red) begin
                n_checks++;
                if (o_pc_redirect_target !== tgt) begin
                    n_fail++; $display("FAIL rnd_target[%0d] got %h want %h", i, o_pc_redirect_target, tgt);
                end
            end
            tick();
            if (red) m_fpc = tgt;
            else if (!stall) m_fpc = m_fpc + 32'd4;
            n_checks++;
            if (dut_ex !== m_ex) begin n_fail++; $display("FAIL rnd_ex[%0d] got %h want %h", i, dut_ex, m_ex); end
            n_checks++;
            if (o_illegal_seen !== m_ill) begin
                n_fail++; $display("FAIL rnd_illegal_seen[%0d] got %b want %b", i, o_illegal_seen, m_ill);
            end
        end
    endtask

    initial begin
        m_ifv = 0; m_ifi = NOP; m_ifp = RST_A; m_if4 = RST_A + 32'd4;
        m_ex = '0; m_ill = 0; m_fpc = '0;
        test_reset();
        test_addi();
        test_branch_taken();
        test_branch_not_taken();
        test_jalr_stall();
        test_x0_and_reset();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
